// File: rtl/reg_unit.sv
// RV32I integer register file: two combinational read ports, one synchronous write port.
// x0 is hardwired to zero; asynchronous active-low reset clears every register.
module reg_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  parameter int unsigned AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] wd,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2
);

  logic [XLEN-1:0] regs [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (rd != '0)) begin
      regs[rd] <= wd;
    end
  end

  // No write-to-read bypass: reads see the pre-edge contents.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (rs1 != '0) rd1 = regs[rs1];
    if (rs2 != '0) rd2 = regs[rs2];
  end

endmodule

// File: tb/tb_reg_unit.sv
// Self-checking bench for reg_unit: directed scenarios then randomized traffic vs. an array model.
module tb_reg_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;
  logic [31:0] wd = '0;
  logic [31:0] rd1, rd2;

  int total = 0;
  int bad = 0;
  logic [31:0] m [32];

  reg_unit #(.XLEN(32), .NREGS(32)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .rs1(rs1), .rs2(rs2),
    .rd(rd), .wd(wd), .rd1(rd1), .rd2(rd2)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] expect_rd(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : m[a];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) m[i] = 32'd0;
  endtask

  // Advance one rising edge, apply the architectural write rule to the model, settle.
  task automatic tick();
    @(posedge clk);
    if (rst_n && we && rd != 5'd0) m[rd] = wd;
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; rd = a; wd = d;
    tick();
    we = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [4:0] a1, input logic [4:0] a2);
    rs1 = a1; rs2 = a2;
    #1;
    check({tag, "_rd1"}, rd1, expect_rd(a1));
    check({tag, "_rd2"}, rd2, expect_rd(a2));
  endtask

  initial begin
    clear_model();

    // Reset, release, read defaults
    #2;
    rs1 = 5'd5; rs2 = 5'd31; #1;
    check("in_reset_rd1", rd1, 32'd0);
    check("in_reset_rd2", rd2, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    read_check("post_reset", 5'd5, 5'd31);
    check("post_reset_const", rd1, 32'd0);

    // Two writes then read
    wr(5'd1, 32'd10);
    wr(5'd2, 32'd20);
    rs1 = 5'd1; rs2 = 5'd2; #1;
    check("x1_read", rd1, 32'd10);
    check("x2_read", rd2, 32'd20);

    // x0 write ignored
    wr(5'd0, 32'd999);
    rs1 = 5'd0; #1;
    check("x0_zero", rd1, 32'd0);

    // we=0 leaves registers unchanged
    we = 1'b0; rd = 5'd3; wd = 32'hDEADBEEF;
    tick();
    rs1 = 5'd3; #1;
    check("we0_hold", rd1, 32'd0);
    wr(5'd31, 32'hFFFFFFFF);
    rs1 = 5'd31; rs2 = 5'd31; #1;
    check("x31_p1", rd1, 32'hFFFFFFFF);
    check("x31_p2", rd2, 32'hFFFFFFFF);

    // Read during write: old before edge, new after
    wr(5'd4, 32'd7);
    we = 1'b1; rd = 5'd4; wd = 32'd8; rs1 = 5'd4; #1;
    check("rdw_before", rd1, 32'd7);
    tick();
    we = 1'b0;
    check("rdw_after", rd1, 32'd8);

    // Asynchronous reset mid-cycle
    rs1 = 5'd1; #1;
    check("x1_before_rst", rd1, 32'd10);
    #1 rst_n = 1'b0;
    clear_model();
    #1;
    check("async_clear", rd1, 32'd0);
    rs1 = 5'd31; rs2 = 5'd4; #1;
    check("rst_comb_rd1", rd1, 32'd0);
    check("rst_comb_rd2", rd2, 32'd0);
    // Write attempted across an edge while in reset must be lost
    we = 1'b1; rd = 5'd5; wd = 32'h12345678;
    tick();
    we = 1'b0;
    rst_n = 1'b1;
    read_check("after_rst", 5'd1, 5'd5);
    // First edge after release performs the write
    wr(5'd6, 32'hA5A5_0001);
    read_check("resume", 5'd6, 5'd1);

    // Randomized traffic with occasional async reset pulses
    for (int n = 0; n < 400; n++) begin
      we  = ($urandom_range(3) != 0);
      rd  = 5'($urandom_range(31));
      wd  = $urandom;
      rs1 = 5'($urandom_range(31));
      rs2 = ($urandom_range(3) == 0) ? rs1 : 5'($urandom_range(31));
      #1;
      check("rnd_pre_rd1", rd1, expect_rd(rs1));
      check("rnd_pre_rd2", rd2, expect_rd(rs2));
      if ($urandom_range(59) == 0) begin
        rst_n = 1'b0;
        clear_model();
        #1;
        check("rnd_rst_rd1", rd1, 32'd0);
        tick();
        rst_n = 1'b1;
      end else begin
        tick();
      end
      check("rnd_post_rd1", rd1, expect_rd(rs1));
      check("rnd_post_rd2", rd2, expect_rd(rs2));
    end

    // Full sweep of both ports against the model
    we = 1'b0;
    for (int a = 0; a < 32; a++) begin
      read_check("sweep", 5'(a), 5'(31 - a));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
